cdb_arbiter: RTL and testbench

Round-robin arbiter for the common data bus (CDB) that carries functional-unit results back to the register file and reservation stations. Each functional unit (ALU0, ALU1, branch, load/store) completing an operation raises a request carrying the destination tag, register address and result word. One request is granted per cycle, and the winner is broadcast on a registered, single-cycle CDB slot. The block sits downstream of the units fed by the allocator and closes the tag-lock loop.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_rr_picker.sv | 41 ++++
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 tb/tb_cdb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB tag/address/word types and requester indices
// Build option: CDB_FLUSH_EN (consumed by cdb_arbiter) adds the flush port.
// Contents: UNLOCKED tag value, regtag_t/regaddr_t/word_t, CDB_SRC_* indices.
package cdb_arbiter_pkg;

  localparam int REGTAG_W  = 4;
  localparam int REGADDR_W = 5;
  localparam int WORD_W    = 32;

  typedef logic [REGTAG_W-1:0]  regtag_t;
  typedef logic [REGADDR_W-1:0] regaddr_t;
  typedef logic [WORD_W-1:0]    word_t;

  // Tag 0 marks a result that nobody is waiting on.
  localparam regtag_t UNLOCKED = '0;

  localparam int CDB_SRC_ALU0   = 0;
  localparam int CDB_SRC_ALU1   = 1;
  localparam int CDB_SRC_BRANCH = 2;
  localparam int CDB_SRC_LS     = 3;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - combinational rotating-priority picker
// Ports:
//   req_i   N-bit request vector
//   ptr_i   index searched first; search wraps ptr..N-1, 0..ptr-1
//   grant_o one-hot grant (zero when no request)
//   idx_o   encoded index of the grant
//   any_o   high when some request is granted
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit keeps ptr+k exact before wrapping, so N need not be a power of two.
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!any_o && req_i[pos]) begin
        any_o        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
// Build option: CDB_FLUSH_EN adds the flush input.
// Ports:
//   clk, rst (sync active-high), rdy (global enable)
//   req_valid/req_tag/req_addr/req_data  per-requester results (slice i = requester i)
//   req_ready                            one-hot combinational grant
//   cdb_valid/cdb_tag/cdb_addr/cdb_data/cdb_src  registered broadcast slot
//   flush (CDB_FLUSH_EN only)            drops the pending grant and rewinds the pointer
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int TAG_W   = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [REQ_CNT-1:0]           req_valid,
  input  logic [REQ_CNT*TAG_W-1:0]     req_tag,
  input  logic [REQ_CNT*ADDR_W-1:0]    req_addr,
  input  logic [REQ_CNT*DATA_W-1:0]    req_data,
  output logic [REQ_CNT-1:0]           req_ready,
`ifdef CDB_FLUSH_EN
  input  logic                         flush,
`endif
  output logic                         cdb_valid,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [ADDR_W-1:0]            cdb_addr,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [$clog2(REQ_CNT)-1:0]   cdb_src
);

  localparam int SRC_W = $clog2(REQ_CNT);

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [REQ_CNT-1:0] grant;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_any;
  logic              gate;
  logic [TAG_W-1:0]  sel_tag;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [ADDR_W-1:0] cdb_addr_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

  rr_picker #(.N(REQ_CNT), .IW(SRC_W)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // A transfer can only happen when the picker result is allowed onto req_ready.
`ifdef CDB_FLUSH_EN
  assign gate = !rst && rdy && !flush;
`else
  assign gate = !rst && rdy;
`endif

  assign req_ready = gate ? grant : '0;

  always_comb begin
    sel_tag  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (grant[i]) begin
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = (grant_idx == SRC_W'(REQ_CNT-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= TAG_W'(UNLOCKED);
      cdb_addr_q  <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end
`ifdef CDB_FLUSH_EN
    else if (flush) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
    end
`endif
    else if (rdy) begin
      if (grant_any) begin
        ptr_q <= ptr_d;
        // Unlocked results are consumed silently; the payload registers keep the last broadcast.
        if (sel_tag != TAG_W'(UNLOCKED)) begin
          cdb_valid_q <= 1'b1;
          cdb_tag_q   <= sel_tag;
          cdb_addr_q  <= sel_addr;
          cdb_data_q  <= sel_data;
          cdb_src_q   <= grant_idx;
        end else begin
          cdb_valid_q <= 1'b0;
        end
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_addr  = cdb_addr_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a behavioural model
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [3:0]  req_valid;
  logic [15:0] req_tag;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [4:0]  cdb_addr;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
`ifdef CDB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  logic [3:0]  v_a;
  logic [3:0]  t_a [4];
  logic [4:0]  a_a [4];
  logic [31:0] d_a [4];

  always #5 clk = ~clk;

  always_comb begin
    req_valid = v_a;
    req_tag   = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*4 +: 4]   = t_a[i];
      req_addr[i*5 +: 5]  = a_a[i];
      req_data[i*32 +: 32] = d_a[i];
    end
  end

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef CDB_FLUSH_EN
    .flush     (flush),
`endif
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_addr  (cdb_addr),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // Model state: next requester to search from plus the broadcast slot contents.
  int          m_ptr;
  bit          m_valid;
  logic [3:0]  m_tag;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_src;
  int          last_g;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit blocked();
    bit b;
    b = rst || !rdy;
`ifdef CDB_FLUSH_EN
    b = b || flush;
`endif
    return b;
  endfunction

  // Winner = first valid requester walking from m_ptr around the ring.
  function automatic int pick();
    if (blocked()) return -1;
    for (int k = 0; k < 4; k++)
      if (v_a[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_tag = 0; m_addr = 0; m_data = 0; m_src = 0;
  endtask

  // Called at negedge with inputs stable: compare, advance model, step to next negedge.
  task automatic cycle();
    int g;
    #1;
    g = pick();
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_addr", cdb_addr, m_addr);
    chk("cdb_data", cdb_data, m_data);
    chk("cdb_src", cdb_src, m_src);
    last_g = g;
    if (rst) model_reset();
`ifdef CDB_FLUSH_EN
    else if (flush) begin m_ptr = 0; m_valid = 0; end
`endif
    else if (rdy) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % 4;
        if (t_a[g] != 0) begin
          m_valid = 1; m_tag = t_a[g]; m_addr = a_a[g]; m_data = d_a[g]; m_src = g;
        end else m_valid = 0;
      end else m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; rdy = 1; v_a = 4'hf;
    for (int i = 0; i < 4; i++) begin
      t_a[i] = 4'(i + 1); a_a[i] = 5'(i + 10); d_a[i] = 32'h1000 + i;
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset holds with everything requesting.
    repeat (2) begin
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", cdb_valid, 0);
      chk("rst_tag", cdb_tag, 0);
      cycle();
    end
    rst = 0;

    // All four continuously valid: rotation 0,1,2,3,0,... with no bubbles.
    for (int n = 0; n < 8; n++) begin
      #1;
      if (n == 0) chk("first_grant", req_ready, 4'b0001);
      else begin
        chk("rr_src", cdb_src, (n - 1) % 4);
        chk("rr_valid", cdb_valid, 1);
      end
      cycle();
    end
    v_a = 0;
    #1;
    chk("rr_src_last", cdb_src, 3);
    cycle();

    // Single requester ALU1.
    v_a = 4'b0010; t_a[1] = 3; a_a[1] = 7; d_a[1] = 32'hDEADBEEF;
    #1;
    chk("single_ready", req_ready, 4'b0010);
    cycle();
    v_a = 0;
    #1;
    chk("single_valid", cdb_valid, 1);
    chk("single_tag", cdb_tag, 3);
    chk("single_addr", cdb_addr, 7);
    chk("single_data", cdb_data, 32'hDEADBEEF);
    chk("single_src", cdb_src, 1);
    cycle();
    #1;
    chk("single_after", cdb_valid, 0);
    cycle();

    // UNLOCKED from load/store: consumed, not broadcast, pointer wraps to 0.
    v_a = 4'b1000; t_a[3] = 0;
    #1;
    chk("unl_ready", req_ready, 4'b1000);
    cycle();
    v_a = 4'b0101; t_a[0] = 5; t_a[2] = 6;
    #1;
    chk("unl_valid", cdb_valid, 0);
    chk("unl_next", req_ready, 4'b0001);
    cycle();

    // rdy stall: ALU0 broadcast frozen, ALU1 waits.
    v_a = 4'b0001; t_a[0] = 7;
    #1;
    chk("stall_grant0", req_ready, 4'b0001);
    cycle();
    rdy = 0; v_a = 4'b0010; t_a[1] = 9;
    repeat (3) begin
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", cdb_valid, 1);
      chk("stall_tag", cdb_tag, 7);
      chk("stall_src", cdb_src, 0);
      cycle();
    end
    rdy = 1;
    #1;
    chk("stall_resume", req_ready, 4'b0010);
    cycle();
    v_a = 0;
    #1;
    chk("stall_bcast_src", cdb_src, 1);
    chk("stall_bcast_tag", cdb_tag, 9);
    cycle();

`ifdef CDB_FLUSH_EN
    flush = 1; v_a = 4'b0001;
    #1;
    chk("flush_ready", req_ready, 0);
    cycle();
    flush = 0; v_a = 4'b1111;
    #1;
    chk("flush_valid", cdb_valid, 0);
    chk("flush_ptr", req_ready, 4'b0001);
    cycle();
    v_a = 0;
    cycle();
`endif

    // Randomized traffic; requesters hold their request until it is consumed.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 7) != 0);
`ifdef CDB_FLUSH_EN
      flush = ($urandom_range(0, 49) == 0);
`endif
      for (int i = 0; i < 4; i++) begin
        if (!v_a[i] && $urandom_range(0, 1) == 1) begin
          v_a[i] = 1'b1;
          t_a[i] = 4'($urandom_range(0, 15));
          a_a[i] = 5'($urandom);
          d_a[i] = $urandom;
        end
      end
      cycle();
      if (last_g >= 0) v_a[last_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
